vga_console_writer: RTL and testbench

- Bus initiator that drives the VGA text-mode target: turns a byte stream of characters into write cycles on the core-side video bus.
- Bus cycles go into the 80x40 text RAM at VIDEO_ADDR and, optionally, into the cursor registers.
- Tracks row and column, handles control characters and line wrap, and clears each new line as it is entered.
- Sits between a character source (UART receiver or debug port) and the video wrapper's strobe/rw/addr/d_in inputs.

---
 rtl/vga_console_writer_pkg.sv | 32 +++
 rtl/vga_console_writer_if.sv | 20 ++
 rtl/vga_console_writer.sv | 171 +++++++++++++++++
 tb/tb_vga_console_writer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_console_writer_pkg.sv
// Shared types and constants for the VGA console writer.
// Optional cursor-register updates are enabled with VGA_CONSOLE_CURSOR_EN.
package vga_console_pkg;

`ifdef VGA_CONSOLE_CURSOR_EN
  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_PUT, S_NEWLINE, S_CLEAR, S_CURX, S_CURY
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_PUT, S_NEWLINE, S_CLEAR
  } state_t;
`endif

  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  localparam logic [31:0] CRX_OFS = 32'h0000_1000 - 32'd2;
  localparam logic [31:0] CRY_OFS = 32'h0000_1000 - 32'd3;

  localparam logic [31:0] VIDEO_ADDR_DEF = 32'h000B_8000;

  // Cell offset in the text RAM; the whole 80x40 screen fits in 12 bits.
  function automatic logic [11:0] cell_ofs(input logic [5:0] r, input logic [6:0] c,
                                           input logic [11:0] cols);
    return 12'(r) * cols + 12'(c);
  endfunction

endpackage

// File: rtl/vga_console_writer_if.sv
// Character stream and video-bus signals of the console writer.
interface vga_console_writer_if;
  logic        ch_valid;
  logic        ch_ready;
  logic [7:0]  ch_data;
  logic        strobe;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] d_out;

  modport master (
    input  ch_valid, ch_data,
    output ch_ready, strobe, rw, addr, d_out
  );

  modport slave (
    output ch_valid, ch_data,
    input  ch_ready, strobe, rw, addr, d_out
  );
endinterface

// File: rtl/vga_console_writer.sv
// Turns a character stream into text-RAM write cycles, with line wrap and line clearing.
// Define VGA_CONSOLE_CURSOR_EN to also update the cursor registers after each move.
//
// state   | meaning
// IDLE    | ch_ready high, waiting for a character
// DECODE  | classify the latched character
// PUT     | write character at row/col, advance column
// NEWLINE | advance row (wraps to 0), start clearing it
// CLEAR   | one BLANK write per cycle across the new row
// CURX    | write col+1 to the cursor column register (optional)
// CURY    | write row to the cursor row register (optional)
module vga_console_writer
  import vga_console_pkg::*;
#(
  parameter logic [31:0] VIDEO_ADDR = VIDEO_ADDR_DEF,
  parameter int          ROWS       = 40,
  parameter int          COLS       = 80,
  parameter logic [7:0]  BLANK      = 8'h20
) (
  input  logic                  clk,
  input  logic                  reset,
  vga_console_writer_if.master  bus,
  output logic [5:0]            row,
  output logic [6:0]            col
);

  localparam logic [11:0] COLS_W   = 12'(COLS);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);

  state_t      state;
  logic [7:0]  ch_buf;
  logic [6:0]  clr_cnt;
  logic        printable;
  logic [5:0]  row_nxt;

  assign printable = (ch_buf >= CH_PRINT_LO) && (ch_buf <= CH_PRINT_HI);
  assign row_nxt   = (row == LAST_ROW) ? 6'd0 : row + 6'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      bus.ch_ready <= 1'b0;
      bus.strobe   <= 1'b0;
      bus.rw       <= 1'b0;
      bus.addr     <= '0;
      bus.d_out    <= '0;
      row          <= '0;
      col          <= '0;
      clr_cnt      <= '0;
      ch_buf       <= '0;
    end else begin
      // Bus outputs return to zero unless the next state drives a write.
      bus.strobe <= 1'b0;
      bus.rw     <= 1'b0;
      bus.addr   <= '0;
      bus.d_out  <= '0;
      case (state)
        S_IDLE: begin
          bus.ch_ready <= 1'b1;
          if (bus.ch_valid && bus.ch_ready) begin
            ch_buf       <= bus.ch_data;
            bus.ch_ready <= 1'b0;
            state        <= S_DECODE;
          end
        end
        S_DECODE: begin
          state        <= S_IDLE;
          bus.ch_ready <= 1'b1;
          if (printable) begin
            bus.strobe   <= 1'b1;
            bus.rw       <= 1'b1;
            bus.addr     <= VIDEO_ADDR + {20'd0, cell_ofs(row, col, COLS_W)};
            bus.d_out    <= {24'd0, ch_buf};
            bus.ch_ready <= 1'b0;
            state        <= S_PUT;
          end else if (ch_buf == CH_LF) begin
            col          <= '0;
            bus.ch_ready <= 1'b0;
            state        <= S_NEWLINE;
          end else if (ch_buf == CH_CR) begin
            col <= '0;
`ifdef VGA_CONSOLE_CURSOR_EN
            bus.strobe   <= 1'b1;
            bus.rw       <= 1'b1;
            bus.addr     <= VIDEO_ADDR + CRX_OFS;
            bus.d_out    <= 32'd1;
            bus.ch_ready <= 1'b0;
            state        <= S_CURX;
`endif
          end else if (ch_buf == CH_BS && col != 7'd0) begin
            col <= col - 7'd1;
`ifdef VGA_CONSOLE_CURSOR_EN
            bus.strobe   <= 1'b1;
            bus.rw       <= 1'b1;
            bus.addr     <= VIDEO_ADDR + CRX_OFS;
            bus.d_out    <= {25'd0, col};
            bus.ch_ready <= 1'b0;
            state        <= S_CURX;
`endif
          end
        end
        S_PUT: begin
          if (col == LAST_COL) begin
            col   <= '0;
            state <= S_NEWLINE;
          end else begin
            col <= col + 7'd1;
`ifdef VGA_CONSOLE_CURSOR_EN
            bus.strobe <= 1'b1;
            bus.rw     <= 1'b1;
            bus.addr   <= VIDEO_ADDR + CRX_OFS;
            bus.d_out  <= {25'd0, col + 7'd2};
            state      <= S_CURX;
`else
            bus.ch_ready <= 1'b1;
            state        <= S_IDLE;
`endif
          end
        end
        S_NEWLINE: begin
          row        <= row_nxt;
          clr_cnt    <= '0;
          bus.strobe <= 1'b1;
          bus.rw     <= 1'b1;
          bus.addr   <= VIDEO_ADDR + {20'd0, cell_ofs(row_nxt, 7'd0, COLS_W)};
          bus.d_out  <= {24'd0, BLANK};
          state      <= S_CLEAR;
        end
        S_CLEAR: begin
          if (clr_cnt == LAST_COL) begin
`ifdef VGA_CONSOLE_CURSOR_EN
            bus.strobe <= 1'b1;
            bus.rw     <= 1'b1;
            bus.addr   <= VIDEO_ADDR + CRX_OFS;
            bus.d_out  <= 32'd1;
            state      <= S_CURX;
`else
            bus.ch_ready <= 1'b1;
            state        <= S_IDLE;
`endif
          end else begin
            clr_cnt    <= clr_cnt + 7'd1;
            bus.strobe <= 1'b1;
            bus.rw     <= 1'b1;
            bus.addr   <= VIDEO_ADDR + {20'd0, cell_ofs(row, clr_cnt + 7'd1, COLS_W)};
            bus.d_out  <= {24'd0, BLANK};
          end
        end
`ifdef VGA_CONSOLE_CURSOR_EN
        S_CURX: begin
          bus.strobe <= 1'b1;
          bus.rw     <= 1'b1;
          bus.addr   <= VIDEO_ADDR + CRY_OFS;
          bus.d_out  <= {26'd0, row};
          state      <= S_CURY;
        end
        S_CURY: begin
          bus.ch_ready <= 1'b1;
          state        <= S_IDLE;
        end
`endif
        default: begin
          bus.ch_ready <= 1'b1;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_console_writer.sv
// Directed self-checking bench for vga_console_writer.
module tb_vga_console_writer;
  localparam logic [31:0] BASE = 32'h000B_8000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] row;
  logic [6:0] col;

  always #5 clk = ~clk;

  vga_console_writer_if bus();

  vga_console_writer #(.VIDEO_ADDR(BASE), .ROWS(40), .COLS(80), .BLANK(8'h20)) dut (
    .clk(clk), .reset(reset), .bus(bus), .row(row), .col(col)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int xfer_cyc = 0;
  int rdy_cyc = 0;
  int cur_total = 0;

  logic [31:0] t_addr[$];
  logic [31:0] t_data[$];
  int          t_cyc[$];
  bit          t_rdy[$];
  logic [31:0] c_addr[$];
  logic [31:0] c_data[$];
  int          c_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: protocol rules every cycle, writes split into text RAM and cursor logs.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (bus.rw !== bus.strobe) begin
        errors++;
        $display("FAIL rw_vs_strobe cyc=%0d rw=%b strobe=%b", cyc, bus.rw, bus.strobe);
      end
      if (!bus.strobe && (bus.addr !== 32'd0 || bus.d_out !== 32'd0)) begin
        errors++;
        $display("FAIL idle_bus_zero cyc=%0d addr=%h d_out=%h want 0", cyc, bus.addr, bus.d_out);
      end
      if (bus.strobe) begin
        if (bus.addr - BASE < 32'd3200) begin
          t_addr.push_back(bus.addr); t_data.push_back(bus.d_out);
          t_cyc.push_back(cyc); t_rdy.push_back(bus.ch_ready);
        end else begin
          c_addr.push_back(bus.addr); c_data.push_back(bus.d_out); c_cyc.push_back(cyc);
          cur_total++;
        end
      end
    end
  end

  task automatic clear_log();
    t_addr.delete(); t_data.delete(); t_cyc.delete(); t_rdy.delete();
    c_addr.delete(); c_data.delete(); c_cyc.delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!bus.ch_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    rdy_cyc = cyc;
    if (!bus.ch_ready) begin
      checks++; errors++;
      $display("FAIL wait_idle_timeout ch_ready=%b want 1", bus.ch_ready);
    end
  endtask

  task automatic send_char(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!bus.ch_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ch_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout char=%h ch_ready=%b want 1", b, bus.ch_ready);
    end
    bus.ch_valid = 1'b1;
    bus.ch_data  = b;
    @(posedge clk);
    xfer_cyc = cyc;
    #1;
    bus.ch_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.ch_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_log();
    wait_idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ch_valid = 1'b0;
    bus.ch_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.strobe, bus.rw, bus.ch_ready} !== 3'b000 || bus.addr !== 32'd0 || bus.d_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus strobe=%b rw=%b ready=%b addr=%h d_out=%h want all 0",
               bus.strobe, bus.rw, bus.ch_ready, bus.addr, bus.d_out);
    end
    checks++;
    if (row !== 6'd0 || col !== 7'd0) begin
      errors++; $display("FAIL reset_pos row=%0d col=%0d want 0 0", row, col);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.ch_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready ch_ready=%b want 1", bus.ch_ready);
    end
    clear_log();
  endtask

  task automatic test_single_char();
    do_reset();
    send_char(8'h41);
    wait_idle();
    checks++;
    if (t_addr.size() != 1) begin
      errors++; $display("FAIL single_count writes=%0d want 1", t_addr.size());
    end else begin
      checks++;
      if (t_addr[0] !== BASE || t_data[0] !== 32'h41) begin
        errors++; $display("FAIL single_write addr=%h data=%h want %h 41", t_addr[0], t_data[0], BASE);
      end
      checks++;
      if (t_cyc[0] != xfer_cyc + 2) begin
        errors++; $display("FAIL single_latency strobe_cyc=%0d want %0d", t_cyc[0], xfer_cyc + 2);
      end
    end
`ifndef VGA_CONSOLE_CURSOR_EN
    checks++;
    if (rdy_cyc != xfer_cyc + 3) begin
      errors++; $display("FAIL single_ready ready_cyc=%0d want %0d", rdy_cyc, xfer_cyc + 3);
    end
`endif
    checks++;
    if (row !== 6'd0 || col !== 7'd1) begin
      errors++; $display("FAIL single_pos row=%0d col=%0d want 0 1", row, col);
    end
  endtask

  task automatic test_line_wrap();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 80; i++) send_char(8'h78);
    wait_idle();
    checks++;
    if (t_addr.size() != 160) begin
      errors++; $display("FAIL wrap_count writes=%0d want 160", t_addr.size());
    end
    for (int i = 0; i < 160 && i < t_addr.size(); i++) begin
      checks++;
      if (t_addr[i] !== BASE + 32'(i) || t_data[i] !== ((i < 80) ? 32'h78 : 32'h20)) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL wrap_write idx=%0d addr=%h data=%h want %h %h", i, t_addr[i],
                              t_data[i], BASE + 32'(i), (i < 80) ? 32'h78 : 32'h20);
      end
      if (i >= 80) begin
        checks++;
        if (t_rdy[i] !== 1'b0) begin
          errors++; $display("FAIL wrap_ready_low idx=%0d ch_ready=%b want 0", i, t_rdy[i]);
        end
      end
      if (i >= 81) begin
        checks++;
        if (t_cyc[i] != t_cyc[i-1] + 1) begin
          errors++; $display("FAIL wrap_consecutive idx=%0d cyc=%0d want %0d", i, t_cyc[i], t_cyc[i-1] + 1);
        end
      end
    end
    checks++;
    if (row !== 6'd1 || col !== 7'd0) begin
      errors++; $display("FAIL wrap_pos row=%0d col=%0d want 1 0", row, col);
    end
  endtask

  task automatic test_control_chars();
    do_reset();
    send_char(8'h61); send_char(8'h62); send_char(8'h0D); send_char(8'h63);
    wait_idle();
    checks++;
    if (t_addr.size() != 3) begin
      errors++; $display("FAIL cr_count writes=%0d want 3", t_addr.size());
    end else begin
      checks++;
      if (t_addr[2] !== BASE || t_data[2] !== 32'h63) begin
        errors++; $display("FAIL cr_write addr=%h data=%h want %h 63", t_addr[2], t_data[2], BASE);
      end
    end
    send_char(8'h08);
    wait_idle();
    checks++;
    if (col !== 7'd0 || t_addr.size() != 3) begin
      errors++; $display("FAIL bs_move col=%0d writes=%0d want 0 3", col, t_addr.size());
    end
    send_char(8'h08);
    wait_idle();
    checks++;
    if (col !== 7'd0 || t_addr.size() != 3) begin
      errors++; $display("FAIL bs_at_zero col=%0d writes=%0d want 0 3", col, t_addr.size());
    end
    clear_log();
    send_char(8'h07);
    wait_idle();
    checks++;
    if (t_addr.size() != 0 || c_addr.size() != 0 || row !== 6'd0 || col !== 7'd0) begin
      errors++; $display("FAIL bel_ignored writes=%0d row=%0d col=%0d want 0 0 0",
                         t_addr.size() + c_addr.size(), row, col);
    end
  endtask

  task automatic test_lf_row_wrap();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 39; i++) send_char(8'h0A);
    wait_idle();
    checks++;
    if (row !== 6'd39) begin
      errors++; $display("FAIL lf_row39 row=%0d want 39", row);
    end
    clear_log();
    send_char(8'h0A);
    wait_idle();
    checks++;
    if (t_addr.size() != 80) begin
      errors++; $display("FAIL lf_wrap_count writes=%0d want 80", t_addr.size());
    end
    for (int i = 0; i < 80 && i < t_addr.size(); i++) begin
      checks++;
      if (t_addr[i] !== BASE + 32'(i) || t_data[i] !== 32'h20) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL lf_wrap_clear idx=%0d addr=%h data=%h want %h 20",
                              i, t_addr[i], t_data[i], BASE + 32'(i));
      end
    end
    checks++;
    if (row !== 6'd0 || col !== 7'd0) begin
      errors++; $display("FAIL lf_wrap_pos row=%0d col=%0d want 0 0", row, col);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    do_reset();
    send_char(8'h41);
    send_char(8'h0A);
    @(negedge clk);
    while (!(bus.strobe && bus.addr == BASE + 32'd117) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(bus.strobe && bus.addr == BASE + 32'd117)) begin
      errors++; $display("FAIL midclr_reach addr=%h strobe=%b want %h 1", bus.addr, bus.strobe, BASE + 32'd117);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.strobe !== 1'b0 || row !== 6'd0 || col !== 7'd0) begin
      errors++; $display("FAIL midclr_abort strobe=%b row=%0d col=%0d want 0 0 0", bus.strobe, row, col);
    end
    @(negedge clk);
    checks++;
    if (bus.ch_ready !== 1'b1) begin
      errors++; $display("FAIL midclr_ready ch_ready=%b want 1", bus.ch_ready);
    end
  endtask

  task automatic test_cursor();
`ifdef VGA_CONSOLE_CURSOR_EN
    do_reset();
    send_char(8'h5A);
    wait_idle();
    checks++;
    if (t_addr.size() != 1 || c_addr.size() != 2) begin
      errors++; $display("FAIL cursor_count text=%0d cursor=%0d want 1 2", t_addr.size(), c_addr.size());
    end else begin
      checks++;
      if (c_addr[0] !== BASE + 32'hFFE || c_data[0] !== 32'd2 || c_cyc[0] != t_cyc[0] + 1) begin
        errors++; $display("FAIL cursor_x addr=%h data=%h cyc=%0d want %h 2 %0d",
                           c_addr[0], c_data[0], c_cyc[0], BASE + 32'hFFE, t_cyc[0] + 1);
      end
      checks++;
      if (c_addr[1] !== BASE + 32'hFFD || c_data[1] !== 32'd0 || c_cyc[1] != t_cyc[0] + 2) begin
        errors++; $display("FAIL cursor_y addr=%h data=%h cyc=%0d want %h 0 %0d",
                           c_addr[1], c_data[1], c_cyc[1], BASE + 32'hFFD, t_cyc[0] + 2);
      end
    end
`else
    checks++;
    if (cur_total != 0) begin
      errors++; $display("FAIL no_cursor_writes outside_writes=%0d want 0", cur_total);
    end
`endif
  endtask

  initial begin
    bus.ch_valid = 1'b0;
    bus.ch_data  = 8'h00;
    test_reset();
    test_single_char();
    test_line_wrap();
    test_control_chars();
    test_lf_row_wrap();
    test_reset_mid_clear();
    test_cursor();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t want finish", $time);
    $fatal(1, "timeout");
  end
endmodule
